detect_collector: RTL and testbench
===================================

DETECT_COLLECTOR -- requirements
Module: detect_collector

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter TIMEOUT SHALL default to 32'd1000; it is the collect window in clk cycles after the first capture.
REQ-003 Port clk SHALL be an input of width 1: the single rising-edge clock.
REQ-004 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-005 Ports valid_0, valid_1, valid_2 SHALL be inputs of width 1 each: per-channel detection pulse from the threshold detectors.
REQ-006 Ports time_0, time_1, time_2 SHALL be inputs of width 32 each: per-channel detect time, sampled when the matching valid_i is 1.
REQ-007 Ports ack_0, ack_1, ack_2 SHALL be outputs of width 1 each: one-cycle capture acknowledge per channel.
REQ-008 Port out_valid SHALL be an output of width 1: result available.
REQ-009 Port out_ready SHALL be an input of width 1: the consumer accepts the result.
REQ-010 Port ref_time SHALL be an output of width 32: captured time_0.
REQ-011 Ports dt_01 and dt_02 SHALL be outputs of width 32 each: time_1-time_0 and time_2-time_0, two's complement.
REQ-012 Port timeout_err SHALL be an output of width 1: one-cycle pulse when a window expires incomplete.
REQ-013 Port drop_cnt SHALL be an output of width 16: saturating count of discarded detections.

Function
REQ-014 The FSM SHALL have 3 states: IDLE, COLLECT, OUTPUT.
REQ-015 In IDLE, on any valid_i=1, the block SHALL latch time_i, set captured[i], clear the window counter, and go to COLLECT. Simultaneous valids SHALL all be captured in the same cycle.
REQ-016 In COLLECT, a valid_i for an uncaptured channel SHALL be latched and captured[i] set.
REQ-017 In COLLECT, a valid_i for an already-captured channel SHALL be acked, not latched, and SHALL increment drop_cnt.
REQ-018 ack_i SHALL be registered: high exactly one cycle, the cycle after each valid_i accepted in IDLE or COLLECT, including duplicates.
REQ-019 When all three channels are captured, the FSM SHALL enter OUTPUT on the next edge. If all three are captured in the same IDLE cycle, it SHALL go to COLLECT, then OUTPUT.
REQ-020 The window counter SHALL increment each cycle in COLLECT.
REQ-021 When the window counter reaches TIMEOUT-1 with channels still missing, the block SHALL pulse timeout_err for 1 cycle, clear captured[], and return to IDLE; the ensuing drop_cnt increase is at most 1 per window.
REQ-022 In OUTPUT, out_valid SHALL be 1 and ref_time, dt_01, dt_02 SHALL be stable until the cycle with out_valid=1 and out_ready=1; the FSM SHALL then go to IDLE with captured[] cleared.
REQ-023 Latency SHALL be: out_valid asserted 1 cycle after the edge that captured the last channel.
REQ-024 In OUTPUT, valid_i SHALL NOT be acked and SHALL increment drop_cnt by 1 per pulse cycle.
REQ-025 Subtraction SHALL be 32-bit modulo (wrap-around), with no saturation.
REQ-026 drop_cnt SHALL saturate at 16'hFFFF.
REQ-027 When several events occur in one cycle, drop_cnt SHALL add their sum, saturated.

Reset
REQ-028 rst=1 SHALL force state IDLE, captured[]=0, counter=0, all ack_i=0, out_valid=0, timeout_err=0, ref_time/dt_01/dt_02=0, drop_cnt=0.
REQ-029 rst SHALL take priority over every other event, including mid-COLLECT and mid-OUTPUT; any pending result SHALL be discarded without handshake.

Structure
REQ-030 A shared package SHALL hold the state encoding (2 bits), the channel count (3), the time width (32), the drop_cnt width (16), and the TIMEOUT default.
REQ-031 One sub-module, detect_capture, SHALL be instanced per channel; it holds the time latch, the captured flag, and the ack register.

Verification
REQ-032 Bench SHALL cover: valid_0@t0 with time 100, valid_1 with 130 three cycles later, valid_2 with 90 five cycles later -> out_valid 1 cycle after valid_2 captured, ref_time=100, dt_01=30, dt_02=0xFFFFFFF6.
REQ-033 Bench SHALL cover: all three valids in one cycle with times 5/5/7 -> each ack_i high 1 cycle, dt_01=0, dt_02=2.
REQ-034 Bench SHALL cover: TIMEOUT=8, only valid_0 -> timeout_err pulse 8 cycles after capture, state IDLE, no out_valid.
REQ-035 Bench SHALL cover: out_ready=0 for 10 cycles with valid_0 pulsed in OUTPUT -> outputs held, no ack_0, drop_cnt=1; out_ready=1 -> IDLE next cycle.
REQ-036 Bench SHALL cover: duplicate valid_1 in COLLECT -> ack_1 pulses, time unchanged, drop_cnt+1.
REQ-037 Bench SHALL cover: rst asserted mid-COLLECT -> all outputs 0 next cycle, and a later full capture yields a correct result.

Source files
------------

// File: rtl/detect_collector_pkg.sv
// detect_collector_pkg: shared types, widths and helpers for the detect collector
package detect_collector_pkg;
  localparam int NCH = 3;
  localparam int TW = 32;
  localparam int DW = 16;
  localparam logic [31:0] TIMEOUT_DEF = 32'd1000;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [2:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {{(DW-2){1'b0}}, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction
endpackage

// File: rtl/detect_collector_capture.sv
// detect_capture: per-channel time latch, captured flag and registered acknowledge
module detect_capture
  import detect_collector_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          accept,
  input  logic          clr,
  input  logic [TW-1:0] time_in,
  output logic [TW-1:0] time_q,
  output logic          cap_q,
  output logic          ack_q,
  output logic          dup
);
  logic [TW-1:0] time_d;
  logic          cap_d;
  logic          ack_d;
  logic          take;
  // first accepted pulse of a window latches the time; later ones are duplicates
  always_comb begin
    take   = accept & valid & ~cap_q;
    dup    = accept & valid & cap_q;
    time_d = take ? time_in : time_q;
    cap_d  = clr ? 1'b0 : (cap_q | take);
    ack_d  = accept & valid;
  end
  // capture state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= '0;
      cap_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      cap_q  <= cap_d;
      ack_q  <= ack_d;
    end
  end
endmodule

// File: rtl/detect_collector.sv
// detect_collector: gathers one detect time per channel and reports deltas to channel 0
module detect_collector
  import detect_collector_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_0,
  input  logic          valid_1,
  input  logic          valid_2,
  input  logic [TW-1:0] time_0,
  input  logic [TW-1:0] time_1,
  input  logic [TW-1:0] time_2,
  output logic          ack_0,
  output logic          ack_1,
  output logic          ack_2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] ref_time,
  output logic [TW-1:0] dt_01,
  output logic [TW-1:0] dt_02,
  output logic          timeout_err,
  output logic [DW-1:0] drop_cnt
);
  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [TW-1:0]   ref_q, ref_d, dt01_q, dt01_d, dt02_q, dt02_d;
  logic [NCH-1:0]  valid, cap, ack, dup;
  logic [TW-1:0]   tin [NCH];
  logic [TW-1:0]   tq [NCH];
  logic            accept, all_cap, expire, clr, load;
  logic [2:0]      incr;
  assign valid = {valid_2, valid_1, valid_0};
  assign tin[0] = time_0;
  assign tin[1] = time_1;
  assign tin[2] = time_2;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    detect_capture u_cap (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid[i]),
      .accept  (accept),
      .clr     (clr),
      .time_in (tin[i]),
      .time_q  (tq[i]),
      .cap_q   (cap[i]),
      .ack_q   (ack[i]),
      .dup     (dup[i])
    );
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: completion wins over window expiry in the same cycle
  always_comb begin
    all_cap = &cap;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |valid ? COLLECT : IDLE;
      COLLECT: state_d = all_cap ? OUTPUT : (cnt_q == TIMEOUT - 32'd1) ? IDLE : COLLECT;
      OUTPUT:  state_d = out_ready ? IDLE : OUTPUT;
      default: state_d = IDLE;
    endcase
  end
  // outputs, counters and result staging
  always_comb begin
    accept        = (state_q == IDLE) | (state_q == COLLECT);
    expire        = (state_q == COLLECT) & ~all_cap & (cnt_q == TIMEOUT - 32'd1);
    clr           = expire | ((state_q == OUTPUT) & out_ready);
    load          = (state_q == COLLECT) & all_cap;
    out_valid     = state_q == OUTPUT;
    cnt_d         = (state_q == COLLECT) ? cnt_q + 32'd1 : (state_q == IDLE) ? 32'd0 : cnt_q;
    timeout_err_d = expire;
    incr          = {2'b0, dup[0]} + {2'b0, dup[1]} + {2'b0, dup[2]} + {2'b0, expire}
                  + (out_valid ? {2'b0, valid[0]} + {2'b0, valid[1]} + {2'b0, valid[2]} : 3'd0);
    drop_cnt_d    = sat_add(drop_cnt_q, incr);
    ref_d         = load ? tq[0] : ref_q;
    dt01_d        = load ? tq[1] - tq[0] : dt01_q;
    dt02_d        = load ? tq[2] - tq[0] : dt02_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
      ref_q         <= '0;
      dt01_q        <= '0;
      dt02_q        <= '0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      drop_cnt_q    <= drop_cnt_d;
      ref_q         <= ref_d;
      dt01_q        <= dt01_d;
      dt02_q        <= dt02_d;
    end
  end
  assign ack_0       = ack[0];
  assign ack_1       = ack[1];
  assign ack_2       = ack[2];
  assign ref_time    = ref_q;
  assign dt_01       = dt01_q;
  assign dt_02       = dt02_q;
  assign timeout_err = timeout_err_q;
  assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_detect_collector.sv
// tb_detect_collector: directed self-checking bench for detect_collector
module tb_detect_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0;
  logic [31:0] time_0 = '0, time_1 = '0, time_2 = '0;
  logic        ack_0, ack_1, ack_2, out_valid, timeout_err;
  logic        out_ready = 1'b0;
  logic [31:0] ref_time, dt_01, dt_02;
  logic [15:0] drop_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  detect_collector #(.TIMEOUT(32'd8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_0     (valid_0),
    .valid_1     (valid_1),
    .valid_2     (valid_2),
    .time_0      (time_0),
    .time_1      (time_1),
    .time_2      (time_2),
    .ack_0       (ack_0),
    .ack_1       (ack_1),
    .ack_2       (ack_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ref_time    (ref_time),
    .dt_01       (dt_01),
    .dt_02       (dt_02),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_v(input logic v0, input logic v1, input logic v2);
    valid_0 = v0;
    valid_1 = v1;
    valid_2 = v2;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acks", {29'd0, ack_2, ack_1, ack_0}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_ref", ref_time, 32'd0);
    // staggered capture with negative dt_02
    set_v(1, 0, 0); time_0 = 32'd100;
    tick();
    set_v(0, 0, 0);
    chk("a_ack0", {31'd0, ack_0}, 32'd1);
    tick();
    chk("a_ack0_once", {31'd0, ack_0}, 32'd0);
    tick();
    set_v(0, 1, 0); time_1 = 32'd130;
    tick();
    set_v(0, 0, 0);
    chk("a_ack1", {31'd0, ack_1}, 32'd1);
    tick();
    set_v(0, 0, 1); time_2 = 32'd90;
    tick();
    set_v(0, 0, 0);
    chk("a_ack2", {31'd0, ack_2}, 32'd1);
    chk("a_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    chk("a_out_valid", {31'd0, out_valid}, 32'd1);
    chk("a_ref", ref_time, 32'd100);
    chk("a_dt01", dt_01, 32'd30);
    chk("a_dt02", dt_02, 32'hFFFF_FFF6);
    chk("a_drop", {16'd0, drop_cnt}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("a_idle", {31'd0, out_valid}, 32'd0);
    // simultaneous capture
    set_v(1, 1, 1); time_0 = 32'd5; time_1 = 32'd5; time_2 = 32'd7;
    tick();
    set_v(0, 0, 0);
    chk("b_acks", {29'd0, ack_2, ack_1, ack_0}, 32'd7);
    chk("b_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    chk("b_acks_off", {29'd0, ack_2, ack_1, ack_0}, 32'd0);
    chk("b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b_dt01", dt_01, 32'd0);
    chk("b_dt02", dt_02, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // window expiry with only channel 0
    set_v(1, 0, 0); time_0 = 32'd50;
    tick();
    set_v(0, 0, 0);
    for (int k = 0; k < 7; k++) tick();
    chk("c_no_err_early", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("c_timeout", {31'd0, timeout_err}, 32'd1);
    chk("c_no_out", {31'd0, out_valid}, 32'd0);
    chk("c_drop", {16'd0, drop_cnt}, 32'd1);
    tick();
    chk("c_pulse_once", {31'd0, timeout_err}, 32'd0);
    // backpressure with a detection arriving in OUTPUT
    set_v(1, 1, 1); time_0 = 32'd10; time_1 = 32'd20; time_2 = 32'd40;
    tick();
    set_v(0, 0, 0);
    chk("d_ack_idle", {31'd0, ack_0}, 32'd1);
    tick();
    chk("d_out_valid", {31'd0, out_valid}, 32'd1);
    set_v(1, 0, 0); time_0 = 32'd77;
    tick();
    set_v(0, 0, 0);
    chk("d_no_ack0", {31'd0, ack_0}, 32'd0);
    chk("d_drop", {16'd0, drop_cnt}, 32'd2);
    for (int k = 0; k < 9; k++) tick();
    chk("d_held_valid", {31'd0, out_valid}, 32'd1);
    chk("d_held_ref", ref_time, 32'd10);
    chk("d_held_dt01", dt_01, 32'd10);
    chk("d_held_dt02", dt_02, 32'd30);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("d_idle", {31'd0, out_valid}, 32'd0);
    // duplicate channel 1 while collecting
    set_v(0, 1, 0); time_1 = 32'd200;
    tick();
    set_v(0, 0, 0);
    chk("e_ack1", {31'd0, ack_1}, 32'd1);
    tick();
    set_v(0, 1, 0); time_1 = 32'd999;
    tick();
    set_v(0, 0, 0);
    chk("e_dup_ack1", {31'd0, ack_1}, 32'd1);
    chk("e_dup_drop", {16'd0, drop_cnt}, 32'd3);
    set_v(1, 0, 1); time_0 = 32'd150; time_2 = 32'd210;
    tick();
    set_v(0, 0, 0);
    tick();
    chk("e_out_valid", {31'd0, out_valid}, 32'd1);
    chk("e_dt01", dt_01, 32'd50);
    chk("e_dt02", dt_02, 32'd60);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // reset in the middle of a window, then a clean capture
    set_v(1, 0, 0); time_0 = 32'd7;
    tick();
    set_v(0, 1, 0); time_1 = 32'd9;
    tick();
    set_v(0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f_rst_acks", {29'd0, ack_2, ack_1, ack_0}, 32'd0);
    chk("f_rst_out", {31'd0, out_valid}, 32'd0);
    chk("f_rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("f_rst_ref", ref_time, 32'd0);
    chk("f_rst_dt01", dt_01, 32'd0);
    chk("f_rst_dt02", dt_02, 32'd0);
    set_v(1, 1, 1); time_0 = 32'd1000; time_1 = 32'd1003; time_2 = 32'd999;
    tick();
    set_v(0, 0, 0);
    tick();
    chk("f_out_valid", {31'd0, out_valid}, 32'd1);
    chk("f_ref", ref_time, 32'd1000);
    chk("f_dt01", dt_01, 32'd3);
    chk("f_dt02", dt_02, 32'hFFFF_FFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
